// File: rtl/neuron_mac_sequencer.sv
// Single-neuron compute engine: reads N_INPUTS x/w byte pairs from the neuron RAM,
// accumulates the unsigned products, scales and saturates the sum, and writes it back.
module neuron_mac_sequencer #(
    parameter int         N_INPUTS    = 4,
    parameter logic [7:0] INPUT_BASE  = 8'd0,
    parameter logic [7:0] WEIGHT_BASE = 8'd4,
    parameter logic [7:0] OUTPUT_ADDR = 8'd8,
    parameter int         ACC_WIDTH   = 24,
    parameter int         SHIFT       = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic [7:0] ram_read_address,
    output logic       ram_oe,
    input  logic [7:0] ram_read_data,
    output logic [7:0] ram_write_address,
    output logic [7:0] ram_write_data,
    output logic       ram_wre
);

    localparam int                IDX_W    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_X,
        S_FETCH_W,
        S_WRITE,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     index_q, index_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [7:0]           x_q, x_d;
    logic [7:0]           result_q, result_d;
    logic [15:0]          prod;
    logic [7:0]           sat;
    logic [7:0]           idx_ext;

    // Scale the accumulator down, then clamp to the 8-bit output range.
    function automatic logic [7:0] scale_sat(input logic [ACC_WIDTH-1:0] acc);
        logic [ACC_WIDTH-1:0] shifted;
        shifted = acc >> SHIFT;
        if (shifted > ACC_WIDTH'(255)) begin
            return 8'hFF;
        end
        return shifted[7:0];
    endfunction

    assign prod    = x_q * ram_read_data;
    assign sat     = scale_sat(acc_q);
    assign idx_ext = 8'(index_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            index_q  <= '0;
            acc_q    <= '0;
            x_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        acc_d    = acc_q;
        x_d      = x_q;
        result_d = result_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    index_d = '0;
                    state_d = S_FETCH_X;
                end
            end
            S_FETCH_X: begin
                x_d     = ram_read_data;
                state_d = S_FETCH_W;
            end
            S_FETCH_W: begin
                acc_d = acc_q + ACC_WIDTH'(prod);
                if (index_q == LAST_IDX) begin
                    state_d = S_WRITE;
                end else begin
                    index_d = index_q + 1'b1;
                    state_d = S_FETCH_X;
                end
            end
            S_WRITE: begin
                result_d = sat;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // RAM-side strobes and addresses are pure decodes of the registered state.
    always_comb begin
        ram_read_address  = 8'd0;
        ram_oe            = 1'b0;
        ram_write_address = 8'd0;
        ram_write_data    = 8'd0;
        ram_wre           = 1'b0;

        unique case (state_q)
            S_FETCH_X: begin
                ram_read_address = INPUT_BASE + idx_ext;
                ram_oe           = 1'b1;
            end
            S_FETCH_W: begin
                ram_read_address = WEIGHT_BASE + idx_ext;
                ram_oe           = 1'b1;
            end
            S_WRITE: begin
                ram_write_address = OUTPUT_ADDR;
                ram_write_data    = sat;
                ram_wre           = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule
